word_assembler: RTL and testbench

WORD_ASSEMBLER -- requirements
Module: word_assembler

---
 rtl/word_assembler_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/word_assembler.sv | 148 ++++++++++++++
 tb/tb_word_assembler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/word_assembler_pkg.sv
// word_assembler_pkg
//   Shared definitions for the word assembler and its output FIFO:
//   - state_e : assembler FSM state encoding (IDLE / COLLECT / HOLD)
//   - ptr_w   : FIFO pointer width for a given depth
//   - level_w : FIFO occupancy width (must be able to hold DEPTH itself)
//   - cnt_w   : width of a counter that must reach n
package word_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock show-ahead FIFO. The head word is visible on rd_data while
//   the FIFO is non-empty (rd_data reads 0 when empty). Push into a full FIFO
//   is accepted only when a pop happens on the same edge.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wr_data     write request and data
//   pop               read request (ignored while empty)
//   rd_data           head-of-FIFO word
//   full, empty       status flags
//   level             current occupancy (0..DEPTH)
module sync_fifo
  import word_assembler_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (do_push ? PW'(1) : PW'(0));
    rd_ptr_d = rd_ptr_q + (do_pop  ? PW'(1) : PW'(0));
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; stale contents are never visible because
  // rd_data is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/word_assembler.sv
// word_assembler
//   Packs BYTES symbols of IN_W bits into one OUT_W word and queues finished
//   words in a show-ahead FIFO. A completed word that finds the FIFO full is
//   held (in_ready low) until a slot frees. An optional idle timeout drops a
//   partially assembled word.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_data, in_data_ready     input symbol and its valid
//   in_ready                   symbol can be accepted this cycle
//   out_data, out_data_ready   head word and its valid
//   out_ack                    consumer pops the head word
//   level                      FIFO occupancy
//   timeout_err                one-cycle pulse when a partial word is dropped
//   overflow_err               sticky: symbol offered while in_ready was low
module word_assembler
  import word_assembler_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int BYTES     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 0,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_data_ready,
  output logic                       in_ready,
  output logic [IN_W*BYTES-1:0]      out_data,
  output logic                       out_data_ready,
  input  logic                       out_ack,
  output logic [level_w(DEPTH)-1:0]  level,
  output logic                       timeout_err,
  output logic                       overflow_err
);

  localparam int OUT_W  = IN_W * BYTES;
  localparam int CNT_W  = ptr_w(BYTES);
  localparam int IDLE_W = cnt_w(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [OUT_W-1:0]  word_q, word_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_err_q, timeout_err_d;
  logic              overflow_err_q, overflow_err_d;

  logic accept;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty, slot_free;

  assign in_ready       = (state_q != ST_HOLD);
  assign accept         = in_data_ready && in_ready;
  assign fifo_pop       = out_ack && !fifo_empty;
  // A full FIFO still takes a word on an edge where the head is popped.
  assign slot_free      = !fifo_full || fifo_pop;
  assign out_data_ready = !fifo_empty;
  assign timeout_err    = timeout_err_q;
  assign overflow_err   = overflow_err_q;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    word_d         = word_q;
    idle_d         = idle_q;
    fifo_push      = 1'b0;
    timeout_err_d  = 1'b0;
    overflow_err_d = overflow_err_q | (in_data_ready && !in_ready);

    if (accept) begin
      for (int k = 0; k < BYTES; k++) begin
        if (count_q == CNT_W'(k)) begin
          if (MSB_FIRST) word_d[OUT_W-(k+1)*IN_W +: IN_W] = in_data;
          else           word_d[k*IN_W +: IN_W]           = in_data;
        end
      end
      idle_d = '0;
      if (count_q == CNT_W'(BYTES - 1)) begin
        count_d = '0;
        if (slot_free) begin
          fifo_push = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          // Finished word stays in word_q until the FIFO has room.
          state_d = ST_HOLD;
        end
      end else begin
        count_d = count_q + CNT_W'(1);
        state_d = ST_COLLECT;
      end
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (slot_free) begin
            fifo_push = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_COLLECT: begin
          if (TIMEOUT > 0) begin
            if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
              state_d       = ST_IDLE;
              count_d       = '0;
              idle_d        = '0;
              timeout_err_d = 1'b1;
            end else begin
              idle_d = idle_q + IDLE_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      word_q         <= '0;
      idle_q         <= '0;
      timeout_err_q  <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      word_q         <= word_d;
      idle_q         <= idle_d;
      timeout_err_q  <= timeout_err_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (word_d),
    .pop     (fifo_pop),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

endmodule

// File: tb/tb_word_assembler.sv
// tb_word_assembler
//   Directed bench with two assembler instances sharing one clock:
//   u_a : MSB_FIRST=1, TIMEOUT=5, DEPTH=2
//   u_b : MSB_FIRST=0, TIMEOUT=0, DEPTH=4
`timescale 1ns/1ps
module tb_word_assembler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  a_data, b_data;
  logic        a_vld, b_vld, a_ack, b_ack;
  logic        a_in_ready, b_in_ready;
  logic [31:0] a_out, b_out;
  logic        a_odr, b_odr;
  logic [1:0]  a_level;
  logic [2:0]  b_level;
  logic        a_to, b_to, a_ov, b_ov;

  int checks = 0;
  int errors = 0;

  word_assembler #(.IN_W(8), .BYTES(4), .MSB_FIRST(1'b1), .TIMEOUT(5), .DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_data_ready(a_vld),
    .in_ready(a_in_ready), .out_data(a_out), .out_data_ready(a_odr),
    .out_ack(a_ack), .level(a_level), .timeout_err(a_to), .overflow_err(a_ov)
  );

  word_assembler #(.IN_W(8), .BYTES(4), .MSB_FIRST(1'b0), .TIMEOUT(0), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_data_ready(b_vld),
    .in_ready(b_in_ready), .out_data(b_out), .out_data_ready(b_odr),
    .out_ack(b_ack), .level(b_level), .timeout_err(b_to), .overflow_err(b_ov)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic a_send(input logic [7:0] d);
    a_data = d;
    a_vld  = 1'b1;
    @(posedge clk); #1;
    a_vld  = 1'b0;
    $display("a: offered symbol 0x%02h", d);
  endtask

  task automatic b_send(input logic [7:0] d);
    b_data = d;
    b_vld  = 1'b1;
    @(posedge clk); #1;
    b_vld  = 1'b0;
    $display("b: offered symbol 0x%02h", d);
  endtask

  task automatic a_pop();
    a_ack = 1'b1;
    @(posedge clk); #1;
    a_ack = 1'b0;
    $display("a: ack");
  endtask

  task automatic b_pop();
    b_ack = 1'b1;
    @(posedge clk); #1;
    b_ack = 1'b0;
    $display("b: ack");
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_data = '0; b_data = '0;
    a_vld = 1'b0; b_vld = 1'b0; a_ack = 1'b0; b_ack = 1'b0;
    #1;
    // Reset state, observed before any clock edge
    chk("a_rst_in_ready", a_in_ready, 1);
    chk("a_rst_odr", a_odr, 0);
    chk("a_rst_out", a_out, 0);
    chk("a_rst_level", a_level, 0);
    chk("a_rst_to", a_to, 0);
    chk("a_rst_ov", a_ov, 0);
    chk("b_rst_level", b_level, 0);
    chk("b_rst_odr", b_odr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Back-to-back symbols, MSB-first packing, one-cycle latency
    a_send(8'd10); a_send(8'd20); a_send(8'd88);
    chk("a_odr_before_4th", a_odr, 0);
    a_send(8'd54);
    chk("a_odr_after_4th", a_odr, 1);
    chk("a_word0", a_out, 32'h0A145836);
    chk("a_level_1", a_level, 1);
    a_pop();
    chk("a_level_after_pop", a_level, 0);
    chk("a_odr_after_pop", a_odr, 0);
    a_pop();
    chk("a_level_ack_empty", a_level, 0);

    // Timeout drops a partial word after 5 idle cycles
    a_send(8'd10); a_send(8'd20);
    for (int i = 1; i <= 6; i++) begin
      idle(1);
      chk($sformatf("a_timeout_idle%0d", i), a_to, (i == 5) ? 1 : 0);
    end
    chk("a_level_after_timeout", a_level, 0);
    a_send(8'd1); a_send(8'd2); a_send(8'd3); a_send(8'd4);
    chk("a_word_after_timeout", a_out, 32'h01020304);
    a_pop();
    chk("a_empty_after_timeout_word", a_odr, 0);

    // Fill DEPTH=2 FIFO, third word held, 13th symbol refused
    for (int i = 1; i <= 13; i++) a_send(8'(i));
    chk("a_full_level", a_level, 2);
    chk("a_hold_in_ready", a_in_ready, 0);
    chk("a_overflow", a_ov, 1);
    chk("a_full_head", a_out, 32'h01020304);
    a_pop();
    chk("a_pop_push_level", a_level, 2);
    chk("a_released_in_ready", a_in_ready, 1);
    chk("a_head_w1", a_out, 32'h05060708);
    a_pop();
    chk("a_head_w2", a_out, 32'h090A0B0C);
    chk("a_level_w2", a_level, 1);
    a_pop();
    chk("a_level_drained", a_level, 0);
    chk("a_overflow_sticky", a_ov, 1);

    // Reset mid-word with one word queued
    a_send(8'd1); a_send(8'd2); a_send(8'd3); a_send(8'd4);
    a_send(8'h11); a_send(8'h22);
    chk("a_pre_reset_level", a_level, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("a_mid_rst_odr", a_odr, 0);
    chk("a_mid_rst_out", a_out, 0);
    chk("a_mid_rst_level", a_level, 0);
    chk("a_mid_rst_ov", a_ov, 0);
    chk("a_mid_rst_in_ready", a_in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);
    a_send(8'hA1); a_send(8'hA2); a_send(8'hA3);
    chk("a_post_rst_no_early_word", a_odr, 0);
    a_send(8'hA4);
    chk("a_post_rst_word", a_out, 32'hA1A2A3A4);
    chk("a_post_rst_level", a_level, 1);
    a_pop();
    chk("a_post_rst_single_word", a_odr, 0);

    // LSB-first packing with 2-cycle gaps
    b_send(8'd10); idle(2);
    b_send(8'd20); idle(2);
    b_send(8'd88); idle(2);
    chk("b_odr_before_4th", b_odr, 0);
    b_send(8'd54);
    chk("b_word_lsb", b_out, 32'h3658140A);
    chk("b_level_1", b_level, 1);
    b_pop();
    chk("b_level_0", b_level, 0);

    // TIMEOUT=0: a long gap must not drop the partial word
    b_send(8'd1); idle(12);
    chk("b_no_timeout", b_to, 0);
    b_send(8'd2); b_send(8'd3); b_send(8'd4);
    chk("b_word_after_gap", b_out, 32'h04030201);
    b_pop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
